// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch I-port, LSU D-port) sharing one single-outstanding
// memory port, with alternating priority under contention and a response timeout.
module mem_arbiter #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_i,
   input  logic [63:0] i_addr_i,
   output logic        i_gnt_o,
   output logic        i_rvalid_o,
   output logic [31:0] i_rdata_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [7:0]  d_be_i,
   input  logic [63:0] d_addr_i,
   input  logic [63:0] d_wdata_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [63:0] d_rdata_o,
   output logic        m_req_o,
   output logic        m_we_o,
   output logic [7:0]  m_be_o,
   output logic [63:0] m_addr_o,
   output logic [63:0] m_wdata_o,
   input  logic        m_gnt_i,
   input  logic        m_rvalid_i,
   input  logic [63:0] m_rdata_i,
   output logic        busy_o,
   output logic        err_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   state_t     state_reg, state_next;
   owner_t     owner_reg, owner_next;
   owner_t     last_owner_reg, last_owner_next;
   logic       addr2_reg, addr2_next;
   logic [7:0] wait_cnt_reg, wait_cnt_next;
   logic       err_reg, err_next;

   owner_t     winner;
   owner_t     cur_owner;
   logic       req_active;
   logic       granted;
   logic       timeout;
   logic       rsp_fire;
   logic [63:0] rsp_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= OWN_I;
         last_owner_reg <= OWN_I;
         addr2_reg      <= 1'b0;
         wait_cnt_reg   <= 8'd0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         addr2_reg      <= addr2_next;
         wait_cnt_reg   <= wait_cnt_next;
         err_reg        <= err_next;
      end
   end

   // Under contention the side that did not win the previous grant goes first.
   always_comb begin
      winner = OWN_I;
      if (i_req_i && d_req_i)
         winner = (last_owner_reg == OWN_I) ? OWN_D : OWN_I;
      else if (d_req_i)
         winner = OWN_D;
   end

   assign cur_owner  = (state_reg == ST_IDLE) ? winner : owner_reg;
   assign req_active = !rst && (((state_reg == ST_IDLE) && (i_req_i || d_req_i)) ||
                                (state_reg == ST_REQ));
   assign granted    = req_active && m_gnt_i;
   assign timeout    = (wait_cnt_reg == MAX_W);
   assign rsp_fire   = !rst && (state_reg == ST_RESP) && (m_rvalid_i || timeout);

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      addr2_next      = addr2_reg;
      wait_cnt_next   = wait_cnt_reg;
      err_next        = err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (i_req_i || d_req_i) begin
               owner_next = winner;
               state_next = m_gnt_i ? ST_RESP : ST_REQ;
            end
         end
         ST_REQ: begin
            if (m_gnt_i)
               state_next = ST_RESP;
         end
         ST_RESP: begin
            // A real response beats a timeout landing in the same cycle.
            if (m_rvalid_i) begin
               state_next = ST_IDLE;
            end else if (timeout) begin
               state_next = ST_IDLE;
               err_next   = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (granted) begin
         last_owner_next = cur_owner;
         wait_cnt_next   = 8'd0;
         if (cur_owner == OWN_I)
            addr2_next = i_addr_i[2];
      end
   end

   always_comb begin
      m_req_o   = req_active;
      m_we_o    = 1'b0;
      m_be_o    = 8'h00;
      m_addr_o  = 64'd0;
      m_wdata_o = 64'd0;
      if (req_active) begin
         if (cur_owner == OWN_D) begin
            m_we_o    = d_we_i;
            m_be_o    = d_be_i;
            m_addr_o  = d_addr_i;
            m_wdata_o = d_wdata_i;
         end else begin
            m_be_o    = 8'hFF;
            m_addr_o  = i_addr_i;
         end
      end
   end

   assign i_gnt_o    = granted && (cur_owner == OWN_I);
   assign d_gnt_o    = granted && (cur_owner == OWN_D);
   assign rsp_data   = m_rvalid_i ? m_rdata_i : 64'd0;
   assign i_rvalid_o = rsp_fire && (owner_reg == OWN_I);
   assign d_rvalid_o = rsp_fire && (owner_reg == OWN_D);
   assign i_rdata_o  = i_rvalid_o ? (addr2_reg ? rsp_data[63:32] : rsp_data[31:0]) : 32'd0;
   assign d_rdata_o  = d_rvalid_o ? rsp_data : 64'd0;
   assign busy_o     = !rst && (state_reg != ST_IDLE);
   assign err_o      = !rst && err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req_i = 1'b0;
   logic [63:0] i_addr_i = '0;
   logic        i_gnt_o, i_rvalid_o;
   logic [31:0] i_rdata_o;
   logic        d_req_i = 1'b0, d_we_i = 1'b0;
   logic [7:0]  d_be_i = '0;
   logic [63:0] d_addr_i = '0, d_wdata_i = '0;
   logic        d_gnt_o, d_rvalid_o;
   logic [63:0] d_rdata_o;
   logic        m_req_o, m_we_o;
   logic [7:0]  m_be_o;
   logic [63:0] m_addr_o, m_wdata_o;
   logic        m_gnt_i = 1'b0, m_rvalid_i = 1'b0;
   logic [63:0] m_rdata_i = '0;
   logic        busy_o, err_o;

   int checks = 0;
   int failures = 0;

   bit          gnt_q[$];
   bit          rsp_port_q[$];
   logic [63:0] rsp_data_q[$];
   bit          rsp_chk_q[$];

   always #5 clk = ~clk;

   mem_arbiter #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i),
      .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
      .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
      .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
      .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end else begin
         $display("ok   %s value=%h", nm, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_gnt(input bit port);
      gnt_q.push_back(port);
   endtask

   task automatic exp_rsp(input bit port, input logic [63:0] data, input bit chk_data);
      rsp_port_q.push_back(port);
      rsp_data_q.push_back(data);
      rsp_chk_q.push_back(chk_data);
   endtask

   // Monitor: port 0 = I, 1 = D
   always @(negedge clk) begin
      if (i_gnt_o || d_gnt_o) begin
         if (i_gnt_o && d_gnt_o) begin
            chk("gnt_both", 64'd1, 64'd0);
         end else if (gnt_q.size() == 0) begin
            chk("gnt_unexpected", {63'd0, d_gnt_o}, 64'hDEAD);
         end else begin
            automatic bit ep = gnt_q.pop_front();
            chk("gnt_port", {63'd0, d_gnt_o}, {63'd0, ep});
         end
      end
      if (i_rvalid_o || d_rvalid_o) begin
         if (i_rvalid_o && d_rvalid_o) begin
            chk("rvalid_both", 64'd1, 64'd0);
         end else if (rsp_port_q.size() == 0) begin
            chk("rvalid_unexpected", {63'd0, d_rvalid_o}, 64'hDEAD);
         end else begin
            automatic bit          ep = rsp_port_q.pop_front();
            automatic logic [63:0] ed = rsp_data_q.pop_front();
            automatic bit          ec = rsp_chk_q.pop_front();
            chk("rsp_port", {63'd0, d_rvalid_o}, {63'd0, ep});
            if (ec) begin
               if (d_rvalid_o) chk("rsp_d_rdata", d_rdata_o, ed);
               else            chk("rsp_i_rdata", {32'd0, i_rdata_o}, ed);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with requests and grant driven: everything must stay 0
      i_req_i = 1'b1; i_addr_i = 64'h40; m_gnt_i = 1'b1; m_rvalid_i = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_m_req", {63'd0, m_req_o}, 64'd0);
      chk("rst_m_addr", m_addr_o, 64'd0);
      chk("rst_m_be", {56'd0, m_be_o}, 64'd0);
      chk("rst_busy", {63'd0, busy_o}, 64'd0);
      chk("rst_err", {63'd0, err_o}, 64'd0);
      chk("rst_i_rvalid", {63'd0, i_rvalid_o}, 64'd0);
      tick();
      i_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0; i_addr_i = '0;
      rst = 1'b0;
      tick();

      // I-only fetch at 0x1004, grant same cycle, response 2 cycles later
      i_req_i = 1'b1; i_addr_i = 64'h1004; m_gnt_i = 1'b1;
      exp_gnt(1'b0);
      @(negedge clk);
      chk("f_m_req", {63'd0, m_req_o}, 64'd1);
      chk("f_m_addr", m_addr_o, 64'h1004);
      chk("f_m_be", {56'd0, m_be_o}, 64'hFF);
      chk("f_m_we", {63'd0, m_we_o}, 64'd0);
      chk("f_m_wdata", m_wdata_o, 64'd0);
      tick();
      i_req_i = 1'b0; i_addr_i = '0; m_gnt_i = 1'b0;
      @(negedge clk);
      chk("f_busy_resp", {63'd0, busy_o}, 64'd1);
      chk("f_m_req_resp", {63'd0, m_req_o}, 64'd0);
      tick();
      m_rvalid_i = 1'b1; m_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
      exp_rsp(1'b0, 64'hAAAABBBB, 1'b1);
      tick();
      m_rvalid_i = 1'b0; m_rdata_i = '0;
      @(negedge clk);
      chk("f_busy_idle", {63'd0, busy_o}, 64'd0);
      tick();

      // Contention from reset: D, then I, then D
      rst = 1'b1; tick(); rst = 1'b0;
      i_req_i = 1'b1; i_addr_i = 64'h1000;
      d_req_i = 1'b1; d_addr_i = 64'h3000; d_be_i = 8'hFF;
      m_gnt_i = 1'b1;
      exp_gnt(1'b1);
      @(negedge clk);
      chk("c_m_addr_d", m_addr_o, 64'h3000);
      tick();
      m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 64'h0123_4567_89AB_CDEF;
      exp_rsp(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
      tick();
      m_gnt_i = 1'b1; m_rvalid_i = 1'b0;
      exp_gnt(1'b0);
      @(negedge clk);
      chk("c_m_addr_i", m_addr_o, 64'h1000);
      tick();
      m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 64'h5555_6666_7777_8888;
      exp_rsp(1'b0, 64'h77778888, 1'b1);
      tick();
      m_gnt_i = 1'b1; m_rvalid_i = 1'b0;
      exp_gnt(1'b1);
      tick();
      i_req_i = 1'b0; d_req_i = 1'b0; m_gnt_i = 1'b0;
      m_rvalid_i = 1'b1; m_rdata_i = 64'hFEDC_BA98_7654_3210;
      exp_rsp(1'b1, 64'hFEDC_BA98_7654_3210, 1'b1);
      tick();
      m_rvalid_i = 1'b0; i_addr_i = '0;

      // D store with grant delayed 3 cycles: bundle held 4 cycles
      d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 8'h0F; d_addr_i = 64'h2000;
      d_wdata_i = 64'hCAFE_F00D_1234_5678;
      for (int k = 0; k < 4; k++) begin
         m_gnt_i = (k == 3);
         if (k == 3) exp_gnt(1'b1);
         @(negedge clk);
         chk($sformatf("s_m_req_%0d", k), {63'd0, m_req_o}, 64'd1);
         chk($sformatf("s_bundle_%0d", k),
             {m_we_o, m_be_o, m_addr_o[15:0], m_wdata_o[31:0]},
             {1'b1, 8'h0F, 16'h2000, 32'h1234_5678});
         tick();
      end
      d_req_i = 1'b0; d_we_i = 1'b0; m_gnt_i = 1'b0;
      m_rvalid_i = 1'b1; m_rdata_i = 64'h9999;
      exp_rsp(1'b1, 64'd0, 1'b0);
      tick();
      m_rvalid_i = 1'b0; m_rdata_i = '0;

      // Response arrives exactly when the counter hits MAX_WAIT: data wins
      d_req_i = 1'b1; d_be_i = 8'hFF; d_addr_i = 64'h4000; m_gnt_i = 1'b1;
      exp_gnt(1'b1);
      tick();
      d_req_i = 1'b0; m_gnt_i = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      m_rvalid_i = 1'b1; m_rdata_i = 64'h1357_9BDF_2468_ACE0;
      exp_rsp(1'b1, 64'h1357_9BDF_2468_ACE0, 1'b1);
      tick();
      m_rvalid_i = 1'b0;
      @(negedge clk);
      chk("race_err", {63'd0, err_o}, 64'd0);
      chk("race_busy", {63'd0, busy_o}, 64'd0);
      tick();

      // Timeout: no response, pulse with rdata 0 after 4 waiting RESP cycles
      i_req_i = 1'b1; i_addr_i = 64'h1008; m_gnt_i = 1'b1;
      m_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_gnt(1'b0);
      tick();
      i_req_i = 1'b0; m_gnt_i = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      exp_rsp(1'b0, 64'd0, 1'b1);
      tick();
      @(negedge clk);
      chk("to_err", {63'd0, err_o}, 64'd1);
      chk("to_busy", {63'd0, busy_o}, 64'd0);
      tick();
      m_rvalid_i = 1'b1;
      tick();
      m_rvalid_i = 1'b0;
      @(negedge clk);
      chk("to_err_sticky", {63'd0, err_o}, 64'd1);
      tick();

      // Reset mid-response: the later m_rvalid_i must be dropped
      i_req_i = 1'b1; i_addr_i = 64'h100C; m_gnt_i = 1'b1;
      exp_gnt(1'b0);
      tick();
      i_req_i = 1'b0; m_gnt_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 64'h2222_3333_4444_5555;
      @(negedge clk);
      chk("rr_busy", {63'd0, busy_o}, 64'd0);
      chk("rr_err", {63'd0, err_o}, 64'd0);
      tick();
      m_rvalid_i = 1'b0;

      // Upper-word fetch selection after reset
      i_req_i = 1'b1; i_addr_i = 64'h100C; m_gnt_i = 1'b1;
      exp_gnt(1'b0);
      tick();
      i_req_i = 1'b0; m_gnt_i = 1'b0;
      m_rvalid_i = 1'b1; m_rdata_i = 64'h1111_2222_3333_4444;
      exp_rsp(1'b0, 64'h11112222, 1'b1);
      tick();
      m_rvalid_i = 1'b0;
      tick(); tick();

      chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
      chk("rsp_q_empty", 64'(rsp_port_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
